// File: rtl/cordic_calc_sequencer.sv
//==============================================================================
// cordic_calc_sequencer : one-at-a-time request sequencer for the CORDIC calculator
// Revision 1.0
//==============================================================================
`default_nettype none

module cordic_calc_sequencer #(
  parameter int WIDTH   = 32,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  // command port
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [3:0]         cmd_op,
  input  logic [WIDTH-1:0]   cmd_x,
  input  logic [WIDTH-1:0]   cmd_y,
  input  logic [WIDTH-1:0]   cmd_z,
  input  logic [TAG_W-1:0]   cmd_tag,
  // response port
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_result,
  output logic [TAG_W-1:0]   rsp_tag,
  output logic [1:0]         rsp_err,
  output logic [CNT_W-1:0]   rsp_cycles,
  // calculator side
  output logic               calc_enable,
  output logic [3:0]         calc_operation,
  output logic [WIDTH-1:0]   calc_x,
  output logic [WIDTH-1:0]   calc_y,
  output logic [WIDTH-1:0]   calc_z,
  input  logic [WIDTH-1:0]   calc_result,
  input  logic               calc_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [3:0]       OP_NONE  = 4'hF;
  localparam logic [3:0]       OP_LAST  = 4'd9;
  localparam logic [1:0]       ERR_OK   = 2'b00;
  localparam logic [1:0]       ERR_OP   = 2'b01;
  localparam logic [1:0]       ERR_TMO  = 2'b10;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_TMO  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  assign cmd_ready = (state == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      rsp_valid      <= 1'b0;
      rsp_result     <= '0;
      rsp_tag        <= '0;
      rsp_err        <= ERR_OK;
      rsp_cycles     <= '0;
      calc_enable    <= 1'b0;
      calc_operation <= OP_NONE;
      calc_x         <= '0;
      calc_y         <= '0;
      calc_z         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            calc_x  <= cmd_x;
            calc_y  <= cmd_y;
            calc_z  <= cmd_z;
            rsp_tag <= cmd_tag;
            if (cmd_op <= OP_LAST) begin
              calc_operation <= cmd_op;
              calc_enable    <= 1'b1;
              state          <= S_ISSUE;
            end else begin
              // illegal opcode never reaches the calculator
              calc_operation <= OP_NONE;
              rsp_result     <= '0;
              rsp_err        <= ERR_OP;
              rsp_cycles     <= '0;
              rsp_valid      <= 1'b1;
              state          <= S_RESP;
            end
          end
        end

        S_ISSUE: begin
          // done seen here may belong to the previous request
          cnt   <= '0;
          state <= S_WAIT;
        end

        S_WAIT: begin
          if (calc_done) begin
            rsp_result  <= calc_result;
            rsp_err     <= ERR_OK;
            rsp_cycles  <= cnt + CNT_ONE;
            rsp_valid   <= 1'b1;
            calc_enable <= 1'b0;
            state       <= S_RESP;
          end else if (cnt == CNT_LAST) begin
            rsp_result  <= '0;
            rsp_err     <= ERR_TMO;
            rsp_cycles  <= CNT_TMO;
            rsp_valid   <= 1'b1;
            calc_enable <= 1'b0;
            state       <= S_RESP;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cordic_calc_sequencer.sv
//==============================================================================
// tb_cordic_calc_sequencer : scoreboard bench with a behavioural calculator model
// Revision 1.0
//==============================================================================
`default_nettype none

module tb_cordic_calc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_x, cmd_y, cmd_z;
  logic [3:0]  cmd_tag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_tag;
  logic [1:0]  rsp_err;
  logic [7:0]  rsp_cycles;
  logic        calc_enable;
  logic [3:0]  calc_operation;
  logic [31:0] calc_x, calc_y, calc_z;
  logic [31:0] calc_result;
  logic        calc_done;

  cordic_calc_sequencer #(.WIDTH(32), .TAG_W(4), .TIMEOUT(64), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_z(cmd_z), .cmd_tag(cmd_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err), .rsp_cycles(rsp_cycles),
    .calc_enable(calc_enable), .calc_operation(calc_operation),
    .calc_x(calc_x), .calc_y(calc_y), .calc_z(calc_z),
    .calc_result(calc_result), .calc_done(calc_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] result;
    logic [3:0]  tag;
    logic [1:0]  err;
    logic [7:0]  cycles;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  int   hs_edge = 0;
  int   en_hi = 0;

  // calculator model: mode 0 = done after lat enabled cycles, 1 = done always high, 2 = never
  int         mode = 0;
  int         lat = 3;
  logic [7:0] mcnt = 8'd0;

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] x,
                                        input logic [31:0] y, input logic [31:0] z);
    logic signed [63:0] p;
    if (op == 4'd4) begin
      p = 64'($signed(x)) * 64'($signed(z));
      return p[47:16];
    end
    return x + (y ^ z) + {28'd0, op};
  endfunction

  assign calc_result = model(calc_operation, calc_x, calc_y, calc_z);
  assign calc_done   = (mode == 1) ? 1'b1 :
                       (mode == 0) ? (calc_enable && (int'(mcnt) == lat)) : 1'b0;

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    mcnt <= calc_enable ? mcnt + 8'd1 : 8'd0;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // response monitor: every handshake pops the oldest expectation
  always @(negedge clk) begin
    if (calc_enable) en_hi <= en_hi + 1;
    if (!rst && rsp_valid && rsp_ready) begin
      hs_edge = cyc + 1;
      if (sb.size() == 0) begin
        check("rsp_unexpected", 64'(sb.size()), 64'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_result", rsp_result, e.result);
        check("rsp_tag",    rsp_tag,    e.tag);
        check("rsp_err",    rsp_err,    e.err);
        check("rsp_cycles", rsp_cycles, e.cycles);
      end
    end
  end

  function automatic exp_t predict(input logic [3:0] op, input logic [31:0] x,
                                   input logic [31:0] y, input logic [31:0] z,
                                   input logic [3:0] tag);
    exp_t e;
    e.tag = tag;
    if (op > 4'd9) begin
      e.result = 0; e.err = 2'b01; e.cycles = 8'd0;
    end else if (mode == 1) begin
      e.result = model(op, x, y, z); e.err = 2'b00; e.cycles = 8'd1;
    end else if (mode == 0 && lat >= 1 && lat <= 64) begin
      e.result = model(op, x, y, z); e.err = 2'b00; e.cycles = 8'(lat);
    end else begin
      e.result = 0; e.err = 2'b10; e.cycles = 8'd64;
    end
    return e;
  endfunction

  task automatic send(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] z, input logic [3:0] tag, input bit push);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_x = x; cmd_y = y; cmd_z = z; cmd_tag = tag;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("cmd_accept_timeout", cmd_ready, 1);
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    cmd_valid  = 1'b0;
    if (push) sb.push_back(predict(op, x, y, z, tag));
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    int b2b_acc;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_x = 0; cmd_y = 0; cmd_z = 0;
    cmd_tag = 4'd0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready",  cmd_ready,      1);
    check("rst_rsp_valid",  rsp_valid,      0);
    check("rst_rsp_result", rsp_result,     0);
    check("rst_rsp_tag",    rsp_tag,        0);
    check("rst_rsp_err",    rsp_err,        0);
    check("rst_rsp_cycles", rsp_cycles,     0);
    check("rst_calc_en",    calc_enable,    0);
    check("rst_calc_op",    calc_operation, 4'hF);
    check("rst_calc_x",     calc_x,         0);
    rst = 1'b0;

    // MULT 2.0 * 3.0, done after 3 WAIT cycles
    en_hi = 0;
    send(4'd4, 32'h0002_0000, 32'h0, 32'h0003_0000, 4'd5, 1);
    drain();
    check("mult_enable_cycles", 64'(en_hi), 64'd4);
    check("mult_enable_low", calc_enable, 0);

    // illegal opcode
    rsp_ready = 1'b0; en_hi = 0;
    send(4'hC, 32'h1234, 32'h5678, 32'h9ABC, 4'd2, 1);
    @(negedge clk);
    check("illegal_rsp_valid", rsp_valid,      1);
    check("illegal_calc_en",   calc_enable,    0);
    check("illegal_calc_op",   calc_operation, 4'hF);
    rsp_ready = 1'b1;
    drain();
    check("illegal_enable_cycles", 64'(en_hi), 64'd0);

    // timeout, then done exactly on the last WAIT cycle, then one past it
    mode = 2; en_hi = 0;
    send(4'd0, 32'h0001_0000, 32'h0, 32'h0, 4'd7, 1);
    begin
      int n = 0;
      while (!rsp_valid && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("timeout_rsp_valid", rsp_valid, 1);
      check("timeout_enable_low", calc_enable, 0);
      check("timeout_enable_cycles", 64'(en_hi), 64'd65);
    end
    drain();
    mode = 0; lat = 64;
    send(4'd2, 32'h0000_8000, 32'h0001_0000, 32'h0, 4'd8, 1);
    drain();
    lat = 65;
    send(4'd3, 32'h0000_4000, 32'h0000_3000, 32'h0, 4'd10, 1);
    drain();
    lat = 3;

    // stale done held high, response held off for 5 cycles
    mode = 1; rsp_ready = 1'b0;
    send(4'd1, 32'h0000_1111, 32'h0000_2222, 32'h0000_3333, 4'd9, 1);
    @(negedge clk); check("lat_issue_valid", rsp_valid, 0);
    @(negedge clk); check("lat_wait_valid",  rsp_valid, 0);
    @(negedge clk); check("lat_resp_valid",  rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid",  rsp_valid,  1);
      check("hold_ready",  cmd_ready,  0);
      check("hold_cycles", rsp_cycles, 1);
      check("hold_tag",    rsp_tag,    9);
      check("hold_result", rsp_result, model(4'd1, 32'h0000_1111, 32'h0000_2222, 32'h0000_3333));
    end
    rsp_ready = 1'b1;
    drain();
    mode = 0;

    // back-to-back: second request waits for the first response handshake
    rsp_ready = 1'b0;
    send(4'd0, 32'h0000_0100, 32'h0000_0200, 32'h0000_0300, 4'd1, 1);
    fork
      begin
        send(4'd5, 32'h0006_0000, 32'h0000_0007, 32'h0002_0000, 4'd2, 1);
        b2b_acc = accept_cyc;
      end
      begin
        repeat (8) @(negedge clk);
        check("b2b_busy_ready", cmd_ready, 0);
        rsp_ready = 1'b1;
      end
    join
    check("b2b_order", 64'(b2b_acc > hs_edge), 64'd1);
    drain();

    // reset mid-WAIT drops the request silently
    mode = 2;
    send(4'd3, 32'h0000_0AAA, 32'h0000_0BBB, 32'h0000_0CCC, 4'd4, 0);
    repeat (5) @(negedge clk);
    check("midwait_enable", calc_enable, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("post_rst_valid",  rsp_valid,      0);
    check("post_rst_enable", calc_enable,    0);
    check("post_rst_op",     calc_operation, 4'hF);
    check("post_rst_ready",  cmd_ready,      1);
    mode = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("late_done_no_rsp", rsp_valid, 0);
    end
    mode = 0;

    // recovery after reset
    send(4'd6, 32'h0000_0042, 32'h0000_0013, 32'h0000_0077, 4'd11, 1);
    drain();
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cordic_calc_sequencer.md
Name: cordic_calc_sequencer

Overview:
- Initiator-side controller for the CORDIC calculator top level: it drives the calculator's `enable`, `operation`, `x_in`, `y_in` and `z_in`, and consumes its `result` and `done`.
- Accepts tagged operation requests over a valid/ready command port.
- Issues one request at a time to the calculator, waits for `done` with a timeout, and returns result, tag, status and measured latency over a valid/ready response port.
- Sits between the software-facing register or bus logic and the calculator.

Parameters:
- WIDTH, 32, data width of operands and result (Q16.16).
- TAG_W, 4, width of the request tag echoed in the response.
- TIMEOUT, 64, maximum WAIT cycles before the request is aborted; must be ≥ 2.
- CNT_W, 8, width of the latency counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk, input, 1, system clock; all logic on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- cmd_valid, input, 1, request present.
- cmd_ready, output, 1, sequencer can accept a request.
- cmd_op, input, 4, operation code: 0 SIN, 1 COS, 2 ATAN, 3 MOD, 4 MULT, 5 DIV, 6 SINH, 7 COSH, 8 ATANH, 9 MODH.
- cmd_x / cmd_y / cmd_z, input, WIDTH each, signed operands.
- cmd_tag, input, TAG_W, request identifier.
- rsp_valid, output, 1, response present.
- rsp_ready, input, 1, consumer accepts the response.
- rsp_result, output, WIDTH, signed result.
- rsp_tag, output, TAG_W, tag of the completed request.
- rsp_err, output, 2, status: 00 ok, 01 illegal opcode, 10 timeout.
- rsp_cycles, output, CNT_W, WAIT cycles until done, or TIMEOUT on timeout.
- calc_enable, output, 1, calculator enable.
- calc_operation, output, 4, operation to the calculator.
- calc_x / calc_y / calc_z, output, WIDTH each, operands to the calculator.
- calc_result, input, WIDTH, calculator result.
- calc_done, input, 1, calculator result valid.

Behaviour:
- All outputs are registered except `cmd_ready`, which is decoded from state (1 only in IDLE).
- Reset values:
  - state IDLE; `cmd_ready` 1.
  - `rsp_valid` 0, `rsp_result` 0, `rsp_tag` 0, `rsp_err` 00, `rsp_cycles` 0.
  - `calc_enable` 0, `calc_operation` 4'b1111, `calc_x` / `calc_y` / `calc_z` 0.
  - internal counter 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - On `cmd_valid` && `cmd_ready` at an edge, latch the opcode, operands and tag into `calc_operation`, `calc_x` / `calc_y` / `calc_z` and `rsp_tag`.
  - If the opcode is ≤ 9, go to ISSUE and set `calc_enable` to 1.
  - Opcodes 10–15 go directly to RESP with `rsp_err`=01, `rsp_result`=0, `rsp_cycles`=0. `calc_enable` stays 0 and `calc_operation` is forced to 4'b1111.
- ISSUE:
  - Lasts exactly 1 cycle; `calc_enable` is 1 and the counter is cleared to 0.
  - `calc_done` is ignored in this cycle, because it may be stale from the previous request.
  - Next state is WAIT.
- WAIT:
  - `calc_enable` stays 1 and operands are held stable; the counter increments every cycle.
  - The first cycle with `calc_done`=1:
    - capture `calc_result` into `rsp_result`;
    - set `rsp_err`=00 and `rsp_cycles` = counter + 1;
    - clear `calc_enable`;
    - go to RESP.
  - If the counter reaches TIMEOUT-1 with `calc_done` still 0:
    - set `rsp_result`=0, `rsp_err`=10, `rsp_cycles`=TIMEOUT;
    - clear `calc_enable`;
    - go to RESP.
  - If `done` arrives on that same final cycle, it counts as success (done wins over timeout).
- RESP:
  - `rsp_valid`=1; all `rsp_*` outputs are held stable until `rsp_ready`=1 at an edge, then return to IDLE with `rsp_valid` 0.
  - `calc_done` is ignored in RESP.
  - `cmd_ready` is 0 in RESP, so a new command can be accepted at the earliest in the cycle after the response handshake.
- Single outstanding request; no buffering.
- `calc_operation` and the operands keep their last values outside ISSUE/WAIT. Only `calc_enable` qualifies them.
- Minimum latency, accept edge to `rsp_valid`=1: 3 cycles, with `done` present on the first WAIT cycle (ISSUE, WAIT, RESP visible).
- `rsp_cycles` saturates naturally at TIMEOUT. CNT_W must be sized so that it never wraps.
- `rst` asserted in any state, including mid-WAIT with `calc_enable`=1: on the next edge all registers take their reset values and any in-flight request is dropped silently.
- `rst` has priority over every handshake.

Test Plan:
- Reset, then MULT with x=0x00020000, z=0x00030000, tag=5; calc model returns done after 3 cycles with 0x00060000 -> `rsp_valid` with result 0x00060000, tag 5, err 00, cycles 3; `calc_enable` high only during ISSUE/WAIT.
- Opcode 4'b1100, tag 2 -> response 1 cycle after accept: err 01, result 0, cycles 0; `calc_enable` never rises; `calc_operation`=4'b1111.
- Calc model never asserts done, TIMEOUT=64 -> response err 10, result 0, cycles 64; `calc_enable` low the cycle after timeout.
- `calc_done` held high from before the accept -> ignored in ISSUE, captured on the first WAIT cycle, cycles=1; hold `rsp_ready`=0 for 5 cycles -> outputs stable and `cmd_ready`=0 throughout.
- Back-to-back: SIN tag 1, then DIV tag 2 presented while busy -> second request accepted only after the first response handshake; tags returned in order.
- `rst` pulsed for 1 cycle mid-WAIT -> next cycle IDLE, `calc_enable` 0, `rsp_valid` 0, `calc_operation` 4'b1111; a later `done` from the calc model produces no response.
